// File: rtl/cpu_pkg.sv
// Shared definitions for the CSCE611 RV32I pipeline: PC-source encoding,
// bubble instruction and reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JALR   = 2'd2
    } pcsrc_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Stall capture/bypass register for the F->EX handoff: freezes instr/valid
// and PC_EX across a stall and passes the live values through otherwise.
module fetch_hold_reg #(
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        valid_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    logic        held;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic [31:0] pc_q;

    // Capture on the first stalled edge only; later stalled edges keep the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            held       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_valid <= 1'b0;
            pc_q       <= 32'h0000_0000;
        end else if (hold) begin
            held <= 1'b1;
            if (!held) begin
                hold_instr <= instr_in;
                hold_valid <= valid_in;
            end
        end else begin
            held <= 1'b0;
            pc_q <= pc_in;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = held ? hold_instr : instr_in;
    assign valid_out = held ? hold_valid : valid_in;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns PC_F, drives the synchronous ROM, applies
// EX redirects/stalls and squashes wrong-path fetches. Optional: FETCH_PERF_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [1:0]        pcsrc_EX,
    input  logic [31:0]       branch_target_EX,
    input  logic [31:0]       jalr_target_EX,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       PC_F,
    output logic [31:0]       PC_EX,
    output logic [31:0]       instr_EX,
    output logic              valid_EX,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       redirect_count,
`endif
    output logic              misalign
);

    pcsrc_t      sel;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        squash;
    logic [31:0] live_instr;
    logic        live_valid;

    // Decode PC source; the reserved encoding falls back to sequential fetch.
    always_comb begin
        sel = PCSRC_PLUS4;
        case (pcsrc_EX)
            2'd1:    sel = PCSRC_BRANCH;
            2'd2:    sel = PCSRC_JALR;
            default: sel = PCSRC_PLUS4;
        endcase
    end

    assign redirect = (sel != PCSRC_PLUS4);
    assign target   = (sel == PCSRC_JALR) ? jalr_target_EX : branch_target_EX;

    // Next-PC priority: redirect beats stall, stall beats increment.
    always_comb begin
        if (redirect) begin
            next_pc = word_align(target);
        end else if (stall) begin
            next_pc = PC_F;
        end else begin
            next_pc = PC_F + 32'd4;
        end
    end

    // PC, squash flag and misalignment pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_F     <= RESET_PC;
            squash   <= 1'b1;
            misalign <= 1'b0;
        end else begin
            PC_F     <= next_pc;
            squash   <= redirect;
            misalign <= redirect & (|target[1:0]);
        end
    end

    assign imem_addr  = PC_F[ADDR_W+1:2];
    assign live_instr = squash ? NOP_INSTR : imem_rdata;
    assign live_valid = ~squash;

    // A redirect releases any hold so the bubble reaches EX immediately.
    fetch_hold_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall & ~redirect),
        .pc_in     (PC_F),
        .instr_in  (live_instr),
        .valid_in  (live_valid),
        .pc_out    (PC_EX),
        .instr_out (instr_EX),
        .valid_out (valid_EX)
    );

`ifdef FETCH_PERF_EN
    // Performance counters, free-running with 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count    <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if (valid_EX && !stall) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-scenario stimulus tables with an
// expected-value queue compared each cycle against a behavioural ROM.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsrc_EX;
    logic [31:0] branch_target_EX;
    logic [31:0] jalr_target_EX;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC_F;
    logic [31:0] PC_EX;
    logic [31:0] instr_EX;
    logic        valid_EX;
    logic        misalign;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    always #5 clk = ~clk;

    // ROM word n holds 0x100 + n, one-cycle read latency.
    always @(posedge clk) imem_rdata <= 32'h0000_0100 + {20'h0, imem_addr};

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pcsrc_EX         (pcsrc_EX),
        .branch_target_EX (branch_target_EX),
        .jalr_target_EX   (jalr_target_EX),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .PC_F             (PC_F),
        .PC_EX            (PC_EX),
        .instr_EX         (instr_EX),
        .valid_EX         (valid_EX),
`ifdef FETCH_PERF_EN
        .fetch_count      (fetch_count),
        .redirect_count   (redirect_count),
`endif
        .misalign         (misalign)
    );

    typedef struct {
        logic         rst;
        logic         stall;
        logic [1:0]   pcsrc;
        logic [31:0]  tgt;
        logic [109:0] exp;
    } step_t;

    logic [109:0] exp_q[$];
    logic [109:0] obs;
    logic [109:0] expv;
    int vectors = 0;
    int miscompares = 0;

    // Expected {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr}.
    function automatic logic [109:0] ev(input logic [31:0] pcf, input logic [31:0] pcex,
                                        input logic [31:0] instr, input logic vld, input logic mis);
        logic [11:0] a;
        a = pcf[13:2];
        return {pcf, pcex, instr, vld, mis, a};
    endfunction

    function automatic step_t mk(input logic r, input logic s, input logic [1:0] p,
                                 input logic [31:0] t, input logic [109:0] e);
        step_t st;
        st.rst = r; st.stall = s; st.pcsrc = p; st.tgt = t; st.exp = e;
        return st;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Unused target port gets a decoy so a wrong target mux is visible.
    task automatic drive(input step_t s);
        rst              = s.rst;
        stall            = s.stall;
        pcsrc_EX         = s.pcsrc;
        branch_target_EX = (s.pcsrc == 2'd2) ? ~s.tgt : s.tgt;
        jalr_target_EX   = (s.pcsrc == 2'd1) ? ~s.tgt : s.tgt;
        exp_q.push_back(s.exp);
    endtask

    task automatic restart();
        drive(mk(1'b1, 1'b0, 2'd0, 32'h0, 110'h0));
        void'(exp_q.pop_front());
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'b0, 1'b0, 2'd0, 32'h0, 110'h0));
            void'(exp_q.pop_front());
            tick();
        end
    endtask

    task automatic test_reset();
        step_t s[$];
        s.push_back(mk(1'b1, 1'b0, 2'd0, 32'h0,        ev(32'h0, 32'h0, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b1, 1'b1, 2'd1, 32'h0000_0080, ev(32'h0, 32'h0, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b1, 1'b1, 2'd2, 32'h0000_0083, ev(32'h0, 32'h0, 32'h13, 1'b0, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_fetch();
        step_t s[$];
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h4, 32'h0, 32'h100, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h8, 32'h4, 32'h101, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'hC, 32'h8, 32'h102, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL fetch[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0, ev(32'hC, 32'h8, 32'h102, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h10, 32'hC, 32'h103, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h14, 32'h10, 32'h104, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        restart();
        s.push_back(mk(1'b0, 1'b0, 2'd1, 32'h40, ev(32'h40, 32'hC, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  ev(32'h44, 32'h40, 32'h110, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  ev(32'h48, 32'h44, 32'h111, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd1, 32'h43, ev(32'h40, 32'h48, 32'h13, 1'b0, 1'b1)));
        s.push_back(mk(1'b0, 1'b0, 2'd3, 32'h80, ev(32'h44, 32'h40, 32'h110, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL branch[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_stall_redirect();
        step_t s[$];
        s.push_back(mk(1'b0, 1'b1, 2'd2, 32'h26, ev(32'h24, 32'h44, 32'h13, 1'b0, 1'b1)));
        s.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0,  ev(32'h24, 32'h44, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  ev(32'h28, 32'h24, 32'h109, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0,  ev(32'h2C, 32'h28, 32'h10A, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL stall_redirect[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_wrap();
        step_t s[$];
        s.push_back(mk(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC, ev(32'hFFFF_FFFC, 32'h2C, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h0, 32'hFFFF_FFFC, 32'h10FF, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h4, 32'h0, 32'h100, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

    task automatic test_stall_after_reset();
        step_t s[$];
        s.push_back(mk(1'b1, 1'b0, 2'd0, 32'h0, ev(32'h0, 32'h0, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0, ev(32'h0, 32'h0, 32'h13, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h4, 32'h0, 32'h100, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, ev(32'h8, 32'h4, 32'h101, 1'b1, 1'b0)));
        foreach (s[i]) begin
            drive(s[i]);
            tick();
            obs = {PC_F, PC_EX, instr_EX, valid_EX, misalign, imem_addr};
            expv = exp_q.pop_front();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL stall_after_reset[%0d] got=%h exp=%h", i, obs, expv);
            end
        end
    endtask

`ifdef FETCH_PERF_EN
    // Reset, 10 plain edges (first sees the reset bubble), two redirects, one bubble edge.
    task automatic test_perf();
        step_t s[$];
        s.push_back(mk(1'b1, 1'b0, 2'd0, 32'h0, 110'h0));
        for (int k = 0; k < 10; k++) s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, 110'h0));
        s.push_back(mk(1'b0, 1'b0, 2'd1, 32'h80, 110'h0));
        s.push_back(mk(1'b0, 1'b0, 2'd2, 32'h100, 110'h0));
        s.push_back(mk(1'b0, 1'b0, 2'd0, 32'h0, 110'h0));
        foreach (s[i]) begin
            drive(s[i]);
            void'(exp_q.pop_front());
            tick();
        end
        vectors++;
        if (fetch_count !== 32'd10 || redirect_count !== 32'd2) begin
            miscompares++;
            $display("FAIL perf_counts got fetch=%0d redirect=%0d exp fetch=10 redirect=2",
                     fetch_count, redirect_count);
        end
        drive(mk(1'b0, 1'b0, 2'd0, 32'h0, 110'h0));
        void'(exp_q.pop_front());
        tick();
        vectors++;
        if (fetch_count !== 32'd11) begin
            miscompares++;
            $display("FAIL perf_fetch_after got=%0d exp=11", fetch_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; stall = 1'b0; pcsrc_EX = 2'd0;
        branch_target_EX = 32'h0; jalr_target_EX = 32'h0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_stall_redirect();
        test_wrap();
        test_stall_after_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
